// File: rtl/cog_ctr_pkg.sv
// Shared definitions for the cog counter bank: mode codes, control-word
// field positions and the channel-select width helper.
package cog_ctr_pkg;

  localparam int unsigned CTR_W = 32;

  // Control-word field positions
  localparam int unsigned CAP_EN_BIT = 31;
  localparam int unsigned MODE_MSB   = 30;
  localparam int unsigned MODE_LSB   = 26;
  localparam int unsigned BPIN_MSB   = 13;
  localparam int unsigned BPIN_LSB   = 9;
  localparam int unsigned APIN_MSB   = 4;
  localparam int unsigned APIN_LSB   = 0;

  // Mode codes (00001-00011 are legacy PLL codes and behave as off)
  localparam logic [4:0] MODE_OFF        = 5'b00000;
  localparam logic [4:0] MODE_NCO_S      = 5'b00100;
  localparam logic [4:0] MODE_NCO_D      = 5'b00101;
  localparam logic [4:0] MODE_DUTY_S     = 5'b00110;
  localparam logic [4:0] MODE_DUTY_D     = 5'b00111;
  localparam logic [4:0] MODE_POS        = 5'b01000;
  localparam logic [4:0] MODE_POS_FB     = 5'b01001;
  localparam logic [4:0] MODE_POSEDGE    = 5'b01010;
  localparam logic [4:0] MODE_POSEDGE_FB = 5'b01011;
  localparam logic [4:0] MODE_NEG        = 5'b01100;
  localparam logic [4:0] MODE_NEG_FB     = 5'b01101;
  localparam logic [4:0] MODE_NEGEDGE    = 5'b01110;
  localparam logic [4:0] MODE_NEGEDGE_FB = 5'b01111;
  localparam logic [4:0] MODE_LOGIC      = 5'b10000;

  // Channel-select width: at least one bit even for a single channel
  function automatic int unsigned ch_sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cog_ctr_chan.sv
// One counter channel: control/frequency/phase registers, pin sampling,
// trigger and A/B output decode, sticky overflow and edge capture.
// Capture registers exist only when CTR_CAPTURE_EN is defined.
module cog_ctr_chan
  import cog_ctr_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned NPIN = 32
) (
  input  logic            clk_cog,
  input  logic            res,
  input  logic            ena,
  input  logic            wr_ctr,
  input  logic            wr_frq,
  input  logic            wr_phs,
  input  logic [31:0]     data,
  input  logic [NPIN-1:0] pin_in,
  input  logic            cap_ack,
  output logic [W-1:0]    phs,
  output logic            ovf,
  output logic [NPIN-1:0] pin_out_c,
  output logic [W-1:0]    cap,
  output logic            cap_vld
);

  logic [31:0]  ctr_q, ctr_d;
  logic [W-1:0] frq_q, frq_d;
  logic [W-1:0] phs_q, phs_d;
  logic [W-1:0] cap_q, cap_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic         cap_vld_q, cap_vld_d;
  logic [1:0]   dly_q, dly_d;

  logic [4:0]   mode;
  logic [4:0]   apin;
  logic [4:0]   bpin;
  logic [31:0]  pin_ext;
  logic         pin_a;
  logic         pin_b;
  logic [3:0]   lut;
  logic         trig;
  logic         out_a;
  logic         out_b;
  logic [31:0]  drv;
  logic [W:0]   sum;
  logic         unused_c;

  // Control fields not decoded here (and data bits above W) are sunk
  assign unused_c = ^{data, ctr_q, cap_ack};

  // Mode decode: trigger, A/B outputs and their placement on the pin bus
  always_comb begin
    mode    = ctr_q[MODE_MSB:MODE_LSB];
    apin    = ctr_q[APIN_MSB:APIN_LSB];
    bpin    = ctr_q[BPIN_MSB:BPIN_LSB];
    pin_ext = 32'(pin_in);
    pin_a   = pin_ext[apin];
    pin_b   = pin_ext[bpin];
    lut     = mode[3:0];
    trig    = 1'b0;
    out_a   = 1'b0;
    out_b   = 1'b0;
    if (mode[4]) begin
      trig = lut[dly_q];
    end else begin
      case (mode)
        MODE_NCO_S:  begin trig = 1'b1; out_a = phs_q[W-1]; end
        MODE_NCO_D:  begin trig = 1'b1; out_a = phs_q[W-1]; out_b = !phs_q[W-1]; end
        MODE_DUTY_S: begin trig = 1'b1; out_a = carry_q; end
        MODE_DUTY_D: begin trig = 1'b1; out_a = carry_q; out_b = !carry_q; end
        MODE_POS, MODE_POS_FB:         trig = dly_q[0];
        MODE_POSEDGE, MODE_POSEDGE_FB: trig = (dly_q == 2'b01);
        MODE_NEG, MODE_NEG_FB:         trig = !dly_q[0];
        MODE_NEGEDGE, MODE_NEGEDGE_FB: trig = (dly_q == 2'b10);
        default: ;
      endcase
      if (mode[3] && mode[0]) out_b = !dly_q[0];
    end
    // Pin indices beyond NPIN fall off the top when truncating
    drv       = (32'(out_b) << bpin) | (32'(out_a) << apin);
    pin_out_c = NPIN'(drv);
  end

  // Next-state: sampling, register writes, accumulate, overflow, capture
  always_comb begin
    ctr_d     = ctr_q;
    frq_d     = frq_q;
    phs_d     = phs_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    dly_d     = dly_q;
    cap_d     = cap_q;
    cap_vld_d = cap_vld_q;
    sum       = {1'b0, phs_q} + {1'b0, frq_q};

    if (mode[4:3] != 2'b00) dly_d = {mode[4] ? pin_b : dly_q[0], pin_a};

    if (wr_frq) frq_d = data[W-1:0];

    if (wr_phs) begin
      phs_d   = data[W-1:0];
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (trig) begin
      phs_d   = sum[W-1:0];
      carry_d = sum[W];
      if (sum[W]) ovf_d = 1'b1;
    end

    // Cog disable wipes every control word and blocks the write
    if (!ena) begin
      ctr_d = '0;
    end else if (wr_ctr) begin
      ctr_d = data;
      ovf_d = 1'b0;
    end

`ifdef CTR_CAPTURE_EN
    if (ctr_q[CAP_EN_BIT] && (mode[4:3] != 2'b00) && (dly_q == 2'b01)) begin
      cap_d     = phs_q;
      cap_vld_d = 1'b1;
    end else if (cap_ack) begin
      cap_vld_d = 1'b0;
    end
`else
    cap_d     = '0;
    cap_vld_d = 1'b0;
`endif
  end

  // Channel state registers
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      ctr_q     <= '0;
      frq_q     <= '0;
      phs_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      dly_q     <= 2'b00;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      frq_q     <= frq_d;
      phs_q     <= phs_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      dly_q     <= dly_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  assign phs     = phs_q;
  assign ovf     = ovf_q;
  assign cap     = cap_q;
  assign cap_vld = cap_vld_q;

endmodule

// File: rtl/cog_ctr_bank.sv
// Multi-channel cog counter bank: write demux to NCH channels, OR of all
// channel pin drives, and concatenation of per-channel state outputs.
// Optional edge capture is enabled by defining CTR_CAPTURE_EN.
module cog_ctr_bank
  import cog_ctr_pkg::*;
#(
  parameter int unsigned NCH  = 2,
  parameter int unsigned W    = 32,
  parameter int unsigned NPIN = 32
) (
  input  logic                     clk_cog,
  input  logic                     res,
  input  logic                     ena,
  input  logic [ch_sel_w(NCH)-1:0] wr_sel,
  input  logic                     wr_ctr,
  input  logic                     wr_frq,
  input  logic                     wr_phs,
  input  logic [31:0]              data,
  input  logic [NPIN-1:0]          pin_in,
  output logic [NCH*W-1:0]         phs,
  output logic [NCH-1:0]           ovf,
  output logic [NPIN-1:0]          pin_out,
  output logic [NCH*W-1:0]         cap,
  output logic [NCH-1:0]           cap_vld,
  input  logic [NCH-1:0]           cap_ack
);

  localparam int unsigned CW = ch_sel_w(NCH);

  logic [NPIN-1:0] chan_pin [NCH];

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    logic sel;
    assign sel = (wr_sel == CW'(n));

    cog_ctr_chan #(
      .W    (W),
      .NPIN (NPIN)
    ) u_chan (
      .clk_cog   (clk_cog),
      .res       (res),
      .ena       (ena),
      .wr_ctr    (wr_ctr && sel),
      .wr_frq    (wr_frq && sel),
      .wr_phs    (wr_phs && sel),
      .data      (data),
      .pin_in    (pin_in),
      .cap_ack   (cap_ack[n]),
      .phs       (phs[n*W +: W]),
      .ovf       (ovf[n]),
      .pin_out_c (chan_pin[n]),
      .cap       (cap[n*W +: W]),
      .cap_vld   (cap_vld[n])
    );
  end

  // Bank pin drive is the OR of every channel's A/B drive
  always_comb begin
    pin_out = '0;
    for (int n = 0; n < NCH; n++) pin_out = pin_out | chan_pin[n];
  end

endmodule

// File: tb/tb_cog_ctr_bank.sv
// Self-checking bench for cog_ctr_bank (NCH=2, W=32, NPIN=32).
// Build with CTR_CAPTURE_EN defined to exercise the capture path as well.
module tb_cog_ctr_bank;

  localparam int unsigned NCH  = 2;
  localparam int unsigned W    = 32;
  localparam int unsigned NPIN = 32;

  logic              clk_cog = 1'b0;
  logic              res;
  logic              ena;
  logic [0:0]        wr_sel;
  logic              wr_ctr, wr_frq, wr_phs;
  logic [31:0]       data;
  logic [NPIN-1:0]   pin_in;
  logic [NCH*W-1:0]  phs;
  logic [NCH-1:0]    ovf;
  logic [NPIN-1:0]   pin_out;
  logic [NCH*W-1:0]  cap;
  logic [NCH-1:0]    cap_vld;
  logic [NCH-1:0]    cap_ack;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  cog_ctr_bank #(.NCH(NCH), .W(W), .NPIN(NPIN)) dut (
    .clk_cog (clk_cog),
    .res     (res),
    .ena     (ena),
    .wr_sel  (wr_sel),
    .wr_ctr  (wr_ctr),
    .wr_frq  (wr_frq),
    .wr_phs  (wr_phs),
    .data    (data),
    .pin_in  (pin_in),
    .phs     (phs),
    .ovf     (ovf),
    .pin_out (pin_out),
    .cap     (cap),
    .cap_vld (cap_vld),
    .cap_ack (cap_ack)
  );

  always #5 clk_cog = ~clk_cog;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ctr [NCH];
  logic [31:0] m_frq [NCH];
  logic [31:0] m_phs [NCH];
  logic [31:0] m_cap [NCH];
  logic        m_carry [NCH];
  logic        m_ovf [NCH];
  logic        m_cv [NCH];
  logic [1:0]  m_smp [NCH];   // {older sample (or B pin), latest A sample}

  function automatic logic pin_at(input logic [4:0] i);
    return (32'(i) < NPIN) ? pin_in[i] : 1'b0;
  endfunction

  function automatic logic m_trig(input logic [4:0] m, input logic [1:0] d);
    if (m >= 5'd16) return m[d];
    if (m >= 5'd4 && m <= 5'd7) return 1'b1;
    if (m >= 5'd8) begin
      if (m[1]) return m[2] ? (d == 2'b10) : (d == 2'b01);
      return m[2] ? !d[0] : d[0];
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] nx_smp(input int n);
    logic [4:0] m;
    m = m_ctr[n][30:26];
    if (m < 5'd8) return m_smp[n];
    return {(m >= 5'd16) ? pin_at(m_ctr[n][13:9]) : m_smp[n][0], pin_at(m_ctr[n][4:0])};
  endfunction

  function automatic logic sel_is(input int n);
    return int'(wr_sel) == n;
  endfunction

  function automatic logic [32:0] nx_acc(input int n);
    if (wr_phs && sel_is(n)) return {1'b0, data};
    if (m_trig(m_ctr[n][30:26], m_smp[n])) return {1'b0, m_phs[n]} + {1'b0, m_frq[n]};
    return {m_carry[n], m_phs[n]};
  endfunction

  function automatic logic nx_ovf(input int n);
    logic [32:0] s;
    s = nx_acc(n);
    if (ena && wr_ctr && sel_is(n)) return 1'b0;
    if (wr_phs && sel_is(n)) return 1'b0;
    if (m_trig(m_ctr[n][30:26], m_smp[n]) && s[32]) return 1'b1;
    return m_ovf[n];
  endfunction

  function automatic logic [31:0] nx_ctr(input int n);
    if (!ena) return 32'h0;
    if (wr_ctr && sel_is(n)) return data;
    return m_ctr[n];
  endfunction

  function automatic logic cap_evt(input int n);
`ifdef CTR_CAPTURE_EN
    return m_ctr[n][31] && (m_ctr[n][30:29] != 2'b00) && (m_smp[n] == 2'b01);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic nx_cv(input int n);
`ifdef CTR_CAPTURE_EN
    if (cap_evt(n)) return 1'b1;
    if (cap_ack[n]) return 1'b0;
    return m_cv[n];
`else
    return 1'b0;
`endif
  endfunction

  // Model state advance on each clock, cleared by reset
  always @(posedge clk_cog or posedge res) begin
    if (res) begin
      for (int n = 0; n < NCH; n++) begin
        m_ctr[n] <= '0; m_frq[n] <= '0; m_phs[n] <= '0; m_cap[n] <= '0;
        m_carry[n] <= 1'b0; m_ovf[n] <= 1'b0; m_cv[n] <= 1'b0; m_smp[n] <= 2'b00;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        m_smp[n]              <= nx_smp(n);
        m_ctr[n]              <= nx_ctr(n);
        m_frq[n]              <= (wr_frq && sel_is(n)) ? data : m_frq[n];
        {m_carry[n], m_phs[n]} <= nx_acc(n);
        m_ovf[n]              <= nx_ovf(n);
        m_cap[n]              <= cap_evt(n) ? m_phs[n] : m_cap[n];
        m_cv[n]               <= nx_cv(n);
      end
    end
  end

  function automatic logic [63:0] exp_phs();
    logic [63:0] v;
    for (int n = 0; n < NCH; n++) v[n*W +: W] = m_phs[n];
    return v;
  endfunction

  function automatic logic [63:0] exp_cap();
    logic [63:0] v;
    for (int n = 0; n < NCH; n++) v[n*W +: W] = m_cap[n];
    return v;
  endfunction

  function automatic logic [1:0] exp_ovf();
    logic [1:0] v;
    for (int n = 0; n < NCH; n++) v[n] = m_ovf[n];
    return v;
  endfunction

  function automatic logic [1:0] exp_cv();
    logic [1:0] v;
    for (int n = 0; n < NCH; n++) v[n] = m_cv[n];
    return v;
  endfunction

  function automatic logic [31:0] exp_pin();
    logic [31:0] v;
    logic [4:0]  m;
    logic        a, b, msb;
    v = '0;
    for (int n = 0; n < NCH; n++) begin
      m   = m_ctr[n][30:26];
      msb = m_phs[n][W-1];
      a   = 1'b0;
      b   = 1'b0;
      if (m == 5'd4 || m == 5'd5) a = msb;
      if (m == 5'd5) b = !msb;
      if (m == 5'd6 || m == 5'd7) a = m_carry[n];
      if (m == 5'd7) b = !m_carry[n];
      if (m >= 5'd8 && m <= 5'd15 && m[0]) b = !m_smp[n][0];
      if (a && 32'(m_ctr[n][4:0]) < NPIN) v[m_ctr[n][4:0]] = 1'b1;
      if (b && 32'(m_ctr[n][13:9]) < NPIN) v[m_ctr[n][13:9]] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk_cog) begin
    if (chk_on && !res) begin
      chk("cmp_phs", 64'(phs), exp_phs());
      chk("cmp_ovf", 64'(ovf), 64'(exp_ovf()));
      chk("cmp_pin", 64'(pin_out), 64'(exp_pin()));
      chk("cmp_cap", 64'(cap), exp_cap());
      chk("cmp_cap_vld", 64'(cap_vld), 64'(exp_cv()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_cog);
    #2;
  endtask

  task automatic wr(input int sel, input logic c, input logic f, input logic p,
                    input logic [31:0] d);
    wr_sel = 1'(sel);
    wr_ctr = c;
    wr_frq = f;
    wr_phs = p;
    data   = d;
    tick();
    wr_ctr = 1'b0;
    wr_frq = 1'b0;
    wr_phs = 1'b0;
  endtask

  logic [31:0] nco_seq [4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
  logic        nco_pin [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] pat     [8] = '{32'h080, 32'h180, 32'h100, 32'h000,
                               32'h200, 32'h280, 32'h080, 32'h000};

  initial begin
    int hi;
    res = 1'b1; ena = 1'b1; wr_sel = '0; wr_ctr = 0; wr_frq = 0; wr_phs = 0;
    data = '0; pin_in = '0; cap_ack = '0;
    tick(); tick();
    chk("rst_phs", 64'(phs), 64'h0);
    chk("rst_pin", 64'(pin_out), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_cap_vld", 64'(cap_vld), 64'h0);
    res = 1'b0;
    chk_on = 1'b1;

    // NCO single on ch0, pin 5
    wr(0, 0, 1, 0, 32'h4000_0000);
    wr(0, 1, 0, 0, 32'h1000_0005);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("nco_phs", 64'(phs[31:0]), 64'(nco_seq[k]));
      chk("nco_pin5", 64'(pin_out[5]), 64'(nco_pin[k]));
      chk("nco_ovf", 64'(ovf[0]), 64'(k == 3));
    end
    wr(0, 1, 0, 0, 32'h0);
    chk("ctr_wr_clears_ovf", 64'(ovf[0]), 64'h0);

    // Duty differential on ch1, A=2 B=3
    wr(1, 0, 1, 0, 32'h4000_0000);
    wr(1, 0, 0, 1, 32'h0);
    wr(1, 1, 0, 0, 32'h1C00_0602);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      hi += int'(pin_out[2]);
      chk("duty_a", 64'(pin_out[2]), 64'((k % 4) == 3));
      chk("duty_b", 64'(pin_out[3]), 64'((k % 4) != 3));
    end
    chk("duty_hi_count", 64'(hi), 64'd2);
    wr(1, 1, 0, 0, 32'h0);

    // Positive edge counting on ch0, pin 7
    wr(0, 0, 1, 0, 32'h1);
    wr(0, 0, 0, 1, 32'h0);
    wr(0, 1, 0, 0, 32'h2800_0007);
    for (int k = 0; k < 3; k++) begin
      pin_in[7] = 1'b1;
      tick();
      chk("edge_no_inc_yet", 64'(phs[31:0]), 64'(k));
      if (k == 2) wr(0, 0, 0, 1, 32'h55);
      else tick();
      chk("edge_inc", 64'(phs[31:0]), (k == 2) ? 64'h55 : 64'(k + 1));
      pin_in[7] = 1'b0;
      tick(); tick();
    end
    chk("edge_ovf", 64'(ovf[0]), 64'h0);

    // ena low overrides a ctr write
    ena = 1'b0; wr_sel = 1'b0; wr_ctr = 1'b1; data = 32'h1000_0005;
    tick();
    ena = 1'b1; wr_ctr = 1'b0;
    tick(); tick();
    chk("ena_pin_off", 64'(pin_out), 64'h0);
    chk("ena_phs_kept", 64'(phs[31:0]), 64'h55);

    // Logic mode on ch0 and neg-edge with feedback on ch1
    wr(0, 1, 0, 0, 32'h5800_1007);
    wr(1, 0, 1, 0, 32'h1);
    wr(1, 1, 0, 0, 32'h3C00_1409);
    for (int k = 0; k < 8; k++) begin
      pin_in = pat[k];
      tick();
    end
    pin_in = '0;
    tick(); tick();
    chk("fb_pin10", 64'(pin_out[10]), 64'h1);

    // Reset in the middle of accumulation
    wr(1, 0, 1, 0, 32'h6000_0000);
    wr(1, 1, 0, 0, 32'h1000_0003);
    repeat (4) tick();
    chk("pre_rst_ovf1", 64'(ovf[1]), 64'h1);
    res = 1'b1;
    #1;
    chk("mid_rst_phs", 64'(phs), 64'h0);
    chk("mid_rst_ovf", 64'(ovf), 64'h0);
    chk("mid_rst_pin", 64'(pin_out), 64'h0);
    chk("mid_rst_cap_vld", 64'(cap_vld), 64'h0);
    tick();
    res = 1'b0;
    tick();

`ifdef CTR_CAPTURE_EN
    // Capture of pre-update phase on an A-pin rising edge
    wr(0, 0, 1, 0, 32'd3);
    wr(0, 0, 0, 1, 32'd100);
    wr(0, 1, 0, 0, 32'hA000_0007);
    tick();
    pin_in[7] = 1'b1;
    tick(); tick();
    chk("cap_val", 64'(cap[31:0]), 64'd100);
    chk("cap_vld_set", 64'(cap_vld[0]), 64'h1);
    pin_in[7] = 1'b0;
    tick(); tick();
    cap_ack[0] = 1'b1;
    tick();
    cap_ack[0] = 1'b0;
    chk("cap_ack_clr", 64'(cap_vld[0]), 64'h0);
    pin_in[7] = 1'b1;
    tick();
    cap_ack[0] = 1'b1;
    tick();
    cap_ack[0] = 1'b0;
    chk("cap_beats_ack", 64'(cap_vld[0]), 64'h1);
    pin_in[7] = 1'b0;
    tick(); tick();
`else
    // Capture disabled: cap_en and cap_ack have no effect
    wr(0, 1, 0, 0, 32'hA000_0007);
    pin_in[7] = 1'b1;
    cap_ack = 2'b11;
    tick(); tick();
    chk("nocap_cap", 64'(cap), 64'h0);
    chk("nocap_vld", 64'(cap_vld), 64'h0);
    cap_ack = '0;
    pin_in[7] = 1'b0;
    tick();
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
